lut_mult_sched_32b: RTL and testbench
=====================================

Name: lut_mult_sched_32b

Overview:
Round-robin scheduler sharing one multi-cycle 32x32->64 LUT multiplier among NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready, issues one multiply at a time with a start/done handshake, and returns the 64-bit product to the originating requester. It also applies a zero-operand bypass and a done-timeout guard. It sits between client datapaths and the LUT multiplier core.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), requester index width (derived, not overridable)
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk_32b  in  1  clock, all logic on rising edge
reset_32b  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  one-hot grant/accept strobe
req_op_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i]
req_op_b  in  NUM_REQ*32  operand B, same packing
rsp_valid  out  NUM_REQ  one-hot result valid
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_result  out  64  product, shared bus, meaningful where rsp_valid set
rsp_error  out  1  qualifies rsp_result: 1 = timeout abort, result forced 0
mul_start  out  1  one-cycle start pulse to multiplier
mul_op_a  out  32  latched operand A to multiplier
mul_op_b  out  32  latched operand B to multiplier
mul_done  in  1  multiplier completion pulse
mul_result  in  64  multiplier product, valid with mul_done
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync, high): state=IDLE, rr_ptr=0, wait_cnt=0, all outputs 0 (req_ready, rsp_valid, rsp_result, rsp_error, mul_start, mul_op_a/b, busy). Reset mid-operation discards the in-flight op; a later mul_done is ignored because it is sampled only in WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant the first valid index at or after rr_ptr (modulo NUM_REQ). In that same cycle: req_ready[g]=1 combinationally, operands latched into mul_op_a/b, gnt_id<=g. If either operand is 0, go to RESP with result 0 (bypass, no mul_start). Otherwise go to ISSUE. If no req_valid, stay in IDLE.
- ISSUE: mul_start=1 for exactly one cycle, wait_cnt<=0, go to WAIT. mul_done is not sampled in ISSUE.
- WAIT: wait_cnt increments each cycle. If mul_done: rsp_result<=mul_result, rsp_error<=0, go to RESP. Else if wait_cnt==TIMEOUT-1: rsp_result<=0, rsp_error<=1, go to RESP. mul_done in the same cycle as the timeout: done wins.
- RESP: rsp_valid[gnt_id]=1, rsp_result and rsp_error held stable until rsp_ready[gnt_id]. On the handshake: rr_ptr<=(gnt_id+1) mod NUM_REQ, go to IDLE. No new grant in that cycle, so the minimum gap between grants is one idle cycle.
- rsp_ready on non-granted lines is ignored. req_valid may drop without ready; no grant is made then.
- Latency, request accepted at cycle T: mul_start at T+1; mul_done at D>=T+2 gives rsp_valid at D+1. Bypass gives rsp_valid at T+1.
- mul_op_a/b are held constant from ISSUE until IDLE.
- Width: the product is an unsigned full 64-bit result and is passed through unmodified.

Decomposition:
- Shared package lut_mult_pkg: FSM state enum (2-bit), OP_W=32, RES_W=64, and a default TIMEOUT constant.
- Sub-module rr_arbiter: combinational round-robin priority pick (req vector, rr_ptr -> one-hot grant, grant index, any_grant), parameterised by NUM_REQ.
- FSM, timeout counter and response register live in the top.

Test Plan:
- Single requester: req0 with 120,2; model mul_done 3 cycles after mul_start -> rsp_valid[0] with rsp_result=240, rsp_error=0. mul_start pulses exactly once; req_ready[0] is high for exactly 1 cycle.
- All 4 requesters valid at once: (19,17), (3628800,11), (39916800,12), (39916800,3628800). Grants in order 0,1,2,3 with results 323, 39916800, 479001600, 144850083840000. Then req1 and req2 re-assert with rr_ptr=0 after req3 -> req1 is granted first.
- Zero bypass: req2 with 0,39916800 -> no mul_start, rsp_valid[2] one cycle after req_ready[2], rsp_result=0, rsp_error=0.
- Timeout: multiplier never asserts done (TIMEOUT=64) -> rsp_valid at 64 cycles in WAIT, rsp_result=0, rsp_error=1. A second run with mul_done on the final WAIT cycle returns the product with rsp_error=0.
- Backpressure and width: 0xFFFFFFFF x 0xFFFFFFFF with rsp_ready held low for 10 cycles -> rsp_result=0xFFFFFFFE00000001 stable throughout, no new grant until accept.
- Reset mid-WAIT: assert reset_32b for 1 cycle, then a stray mul_done -> all outputs 0, busy=0, no rsp_valid. The next request starts arbitration from index 0.

Source files
------------

// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the LUT multiplier scheduler.
package lut_mult_pkg;

    localparam int unsigned OP_W            = 32;
    localparam int unsigned RES_W           = 64;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/lut_mult_sched_32b_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic [SUM_W-1:0] idx_sum;
    logic [ID_W-1:0]  idx;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx_sum   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = SUM_W'(rr_ptr) + SUM_W'(k);
            if (idx_sum >= SUM_W'(NUM_REQ)) begin
                idx_sum = idx_sum - SUM_W'(NUM_REQ);
            end
            idx = ID_W'(idx_sum);
            if (!any_grant && req[idx]) begin
                any_grant     = 1'b1;
                grant_id      = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_mult_sched_32b.sv
// Round-robin scheduler sharing one multi-cycle 32x32->64 multiplier.
module lut_mult_sched_32b
    import lut_mult_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk_32b,
    input  logic                    reset_32b,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_op_a,
    input  logic [NUM_REQ*OP_W-1:0] req_op_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [RES_W-1:0]        rsp_result,
    output logic                    rsp_error,
    output logic                    mul_start,
    output logic [OP_W-1:0]         mul_op_a,
    output logic [OP_W-1:0]         mul_op_b,
    input  logic                    mul_done,
    input  logic [RES_W-1:0]        mul_result,
    output logic                    busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned PTR_W = ID_W + 1;

    sched_state_t     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, gnt_id_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic [NUM_REQ-1:0] arb_oh;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic [OP_W-1:0]    op_a_sel, op_b_sel;
    logic               sel_zero, timeout_hit, grant_en, accept;
    logic [PTR_W-1:0]   ptr_inc;
    logic [ID_W-1:0]    ptr_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (arb_oh),
        .grant_id  (arb_id),
        .any_grant (arb_any)
    );

    // Operand mux for the arbiter winner.
    always_comb begin
        op_a_sel = '0;
        op_b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_oh[i]) begin
                op_a_sel = op_a_sel | req_op_a[i*OP_W +: OP_W];
                op_b_sel = op_b_sel | req_op_b[i*OP_W +: OP_W];
            end
        end
    end

    assign sel_zero    = (op_a_sel == '0) || (op_b_sel == '0);
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign accept      = (state_q == ST_RESP) && rsp_ready[gnt_id_q];
    assign ptr_inc     = PTR_W'(gnt_id_q) + PTR_W'(1);
    assign ptr_next    = (ptr_inc >= PTR_W'(NUM_REQ)) ? '0 : ID_W'(ptr_inc);

    // State register.
    always_ff @(posedge clk_32b) begin
        if (reset_32b) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state and handshake decode; everything is held off during reset.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        busy      = 1'b1;
        grant_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (arb_any) begin
                    req_ready = arb_oh;
                    grant_en  = 1'b1;
                    state_d   = sel_zero ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = NUM_REQ'(1) << gnt_id_q;
                if (rsp_ready[gnt_id_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset_32b) begin
            req_ready = '0;
            rsp_valid = '0;
            mul_start = 1'b0;
            busy      = 1'b0;
            grant_en  = 1'b0;
        end
    end

    // Operand latch, wait counter, response register and rr pointer.
    always_ff @(posedge clk_32b) begin
        if (reset_32b) begin
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            wait_cnt_q <= '0;
            mul_op_a   <= '0;
            mul_op_b   <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (grant_en) begin
                mul_op_a <= op_a_sel;
                mul_op_b <= op_b_sel;
                gnt_id_q <= arb_id;
                if (sel_zero) begin
                    rsp_result <= '0;
                    rsp_error  <= 1'b0;
                end
            end
            if (state_q == ST_ISSUE) wait_cnt_q <= '0;
            if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                if (mul_done) begin
                    rsp_result <= mul_result;
                    rsp_error  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_result <= '0;
                    rsp_error  <= 1'b1;
                end
            end
            if (accept) rr_ptr_q <= ptr_next;
        end
    end

endmodule

// File: tb/tb_lut_mult_sched_32b.sv
// Randomized self-checking bench for lut_mult_sched_32b.
module tb_lut_mult_sched_32b;

    localparam int NR = 4;
    localparam int TO = 64;

    logic              clk_32b;
    logic              reset_32b;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_op_a;
    logic [NR*32-1:0]  req_op_b;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [63:0]       rsp_result;
    logic              rsp_error;
    logic              mul_start;
    logic [31:0]       mul_op_a;
    logic [31:0]       mul_op_b;
    logic              mul_done;
    logic [63:0]       mul_result;
    logic              busy;

    lut_mult_sched_32b #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_32b    (clk_32b),
        .reset_32b  (reset_32b),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op_a   (req_op_a),
        .req_op_b   (req_op_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .mul_start  (mul_start),
        .mul_op_a   (mul_op_a),
        .mul_op_b   (mul_op_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .busy       (busy)
    );

    initial clk_32b = 1'b0;
    always #5 clk_32b = ~clk_32b;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ptr_m   = 0;
    int          start_cnt = 0;
    int          ready_cnt = 0;
    logic [31:0] opa [NR];
    logic [31:0] opb [NR];

    // Count start pulses and grant cycles away from the active edge.
    always @(negedge clk_32b) begin
        if (mul_start) start_cnt <= start_cnt + 1;
        if (req_ready != '0) ready_cnt <= ready_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: first valid index at or after the pointer.
    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            req_op_a[i*32 +: 32] = opa[i];
            req_op_b[i*32 +: 32] = opb[i];
        end
    endtask

    // One full transaction for the requester the model expects to win.
    // lat: cycles from mul_start to mul_done (> TO means never); hold: rsp_ready stall cycles.
    // Called and returns at 1 time unit after a rising edge.
    task automatic serve(input int lat, input int hold);
        int          id;
        int          n;
        int          n_wait;
        logic [NR-1:0] oh;
        logic [63:0] prod;
        logic [63:0] exp_res;
        logic        exp_err;
        logic        byp;
        id = pick(req_valid, ptr_m);
        if (id < 0) return;
        oh = '0;
        oh[id] = 1'b1;
        prod = 64'(opa[id]) * 64'(opb[id]);
        byp  = (opa[id] == 32'd0) || (opb[id] == 32'd0);
        exp_err = 1'b0;
        if (byp)          exp_res = 64'd0;
        else if (lat > TO) begin exp_res = 64'd0; exp_err = 1'b1; end
        else              exp_res = prod;
        #2;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(posedge clk_32b); #3;
            n++;
        end
        check("grant", 64'(req_ready), 64'(oh));
        check("rsp_idle", 64'(rsp_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        @(posedge clk_32b); #1;
        req_valid[id] = 1'b0;
        #2;
        if (byp) begin
            check("bypass_nostart", 64'(mul_start), 64'd0);
        end else begin
            check("start", 64'(mul_start), 64'd1);
            check("op_a", 64'(mul_op_a), 64'(opa[id]));
            check("op_b", 64'(mul_op_b), 64'(opb[id]));
            check("busy_issue", 64'(busy), 64'd1);
            n_wait = (lat > TO) ? TO : lat;
            for (int k = 1; k <= n_wait; k++) begin
                @(posedge clk_32b); #1;
                if (k == lat) begin
                    mul_done   = 1'b1;
                    mul_result = prod;
                end
                #2;
                check("wait_quiet", 64'({mul_start, rsp_valid, req_ready}), 64'd0);
            end
            @(posedge clk_32b); #1;
            mul_done   = 1'b0;
            mul_result = {$urandom, $urandom};
            #2;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_result", rsp_result, exp_res);
        check("rsp_error", 64'(rsp_error), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_32b); #1;
            rsp_ready = ~oh;
            #2;
            check("hold_valid", 64'(rsp_valid), 64'(oh));
            check("hold_result", rsp_result, exp_res);
            check("hold_nogrant", 64'(req_ready), 64'd0);
        end
        rsp_ready = oh;
        @(posedge clk_32b); #1;
        rsp_ready = '0;
        ptr_m = (id + 1) % NR;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        reset_32b  = 1'b1;
        req_valid  = '1;
        rsp_ready  = '0;
        mul_done   = 1'b0;
        mul_result = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < NR; i++) begin
            opa[i] = 32'(i + 5);
            opb[i] = 32'(i + 7);
        end
        drive_ops();
        @(posedge clk_32b); #3;
        check("reset_no_grant", 64'(req_ready), 64'd0);
        @(posedge clk_32b); #1;
        reset_32b = 1'b0;
        req_valid = '0;
        #2;
        check("reset_ctrl", 64'({req_ready, rsp_valid, mul_start, busy, rsp_error}), 64'd0);
        check("reset_result", rsp_result, 64'd0);
        check("reset_ops", {mul_op_a, mul_op_b}, 64'd0);
        @(posedge clk_32b); #1;

        // All four requesters at once, then req1/req2 with pointer back at 0.
        opa[0] = 32'd19;       opb[0] = 32'd17;
        opa[1] = 32'd3628800;  opb[1] = 32'd11;
        opa[2] = 32'd39916800; opb[2] = 32'd12;
        opa[3] = 32'd39916800; opb[3] = 32'd3628800;
        drive_ops();
        req_valid = 4'b1111;
        for (int t = 0; t < 4; t++) serve(2 + t, 0);
        req_valid = 4'b0110;
        serve(3, 1);
        serve(1, 0);

        // Single requester: one start pulse, one grant cycle.
        opa[0] = 32'd120; opb[0] = 32'd2;
        drive_ops();
        s0 = start_cnt;
        r0 = ready_cnt;
        req_valid = 4'b0001;
        serve(3, 0);
        @(negedge clk_32b); #1;
        check("single_start_once", 64'(start_cnt - s0), 64'd1);
        check("single_ready_once", 64'(ready_cnt - r0), 64'd1);
        @(posedge clk_32b); #1;

        // Zero-operand bypass.
        opa[2] = 32'd0; opb[2] = 32'd39916800;
        drive_ops();
        s0 = start_cnt;
        req_valid = 4'b0100;
        serve(3, 0);
        check("bypass_no_start", 64'(start_cnt - s0), 64'd0);

        // Timeout with no done, then done on the last WAIT cycle.
        opa[1] = 32'd7; opb[1] = 32'd9;
        drive_ops();
        req_valid = 4'b0010;
        serve(1000, 0);
        opa[3] = 32'hDEAD_BEEF; opb[3] = 32'd3;
        drive_ops();
        req_valid = 4'b1000;
        serve(TO, 0);

        // Full-width product under backpressure with another requester waiting.
        opa[0] = 32'hFFFF_FFFF; opb[0] = 32'hFFFF_FFFF;
        opa[1] = 32'd5;         opb[1] = 32'd6;
        drive_ops();
        req_valid = 4'b0011;
        serve(2, 10);
        serve(2, 0);

        // Reset in the middle of WAIT, then a stray done.
        opa[3] = 32'd11; opb[3] = 32'd13;
        drive_ops();
        req_valid = 4'b1000;
        #2;
        check("pre_reset_grant", 64'(req_ready), 64'(4'b1000));
        @(posedge clk_32b); #1;
        req_valid = '0;
        repeat (3) @(posedge clk_32b);
        #1;
        reset_32b = 1'b1;
        @(posedge clk_32b); #1;
        reset_32b  = 1'b0;
        mul_done   = 1'b1;
        mul_result = 64'hFFFF_0000_FFFF_0000;
        #2;
        check("rst_ctrl", 64'({req_ready, rsp_valid, mul_start, busy, rsp_error}), 64'd0);
        check("rst_result", rsp_result, 64'd0);
        check("rst_ops", {mul_op_a, mul_op_b}, 64'd0);
        @(posedge clk_32b); #1;
        mul_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("rst_quiet", 64'({rsp_valid, mul_start, busy}), 64'd0);
            @(posedge clk_32b); #1;
        end
        ptr_m = 0;
        opa[1] = 32'd21; opb[1] = 32'd2;
        opa[2] = 32'd33; opb[2] = 32'd3;
        drive_ops();
        req_valid = 4'b0110;
        serve(2, 0);
        serve(2, 0);

        // Randomized batches against the reference model.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NR; i++) begin
                opa[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
                opb[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            end
            drive_ops();
            req_valid = NR'($urandom_range(1, 15));
            while (req_valid != '0) begin
                serve(($urandom_range(0, 9) == 0) ? 100 : int'($urandom_range(1, 8)),
                      int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
